// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display path: active-low segment
// patterns {a,b,c,d,e,f,g,dp}, the dark/off codes and the scan state encoding.
package ssd_pkg;

  localparam logic [7:0] SEG_0   = 8'h03;
  localparam logic [7:0] SEG_1   = 8'h9F;
  localparam logic [7:0] SEG_2   = 8'h25;
  localparam logic [7:0] SEG_3   = 8'h0D;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h49;
  localparam logic [7:0] SEG_6   = 8'h41;
  localparam logic [7:0] SEG_7   = 8'h1F;
  localparam logic [7:0] SEG_8   = 8'h01;
  localparam logic [7:0] SEG_9   = 8'h09;
  localparam logic [7:0] SEG_A   = 8'h11;
  localparam logic [7:0] SEG_B   = 8'hC1;
  localparam logic [7:0] SEG_C   = 8'h63;
  localparam logic [7:0] SEG_D   = 8'h85;
  localparam logic [7:0] SEG_E   = 8'h61;
  localparam logic [7:0] SEG_F   = 8'h71;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  // One state per digit slot; the value doubles as the digit index.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } scan_state_t;

  function automatic logic [7:0] seg_lut(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_decode.sv
// Combinational hex-code to active-low seven-segment decoder with decimal
// point; shared with the single-digit display path.
module ssd_decode
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    seg = seg_lut(code);
    if (dp) seg[0] = 1'b0;
  end

endmodule

// File: rtl/ssd_scan4.sv
// Four-digit multiplexed seven-segment scanner for a common-anode display:
// per-frame input snapshot, leading-zero blanking and a frame-align pulse.
module ssd_scan4
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  input  logic        blank,
  output logic [7:0]  display,
  output logic [3:0]  ssd_ctl,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  scan_state_t      state, state_next;

  logic [15:0] sh_digits;
  logic [3:0]  sh_dp;
  logic        sh_blank;

  logic        capture;
  logic [15:0] cap_digits;
  logic [3:0]  cap_dp;
  logic        cap_blank;

  logic [1:0]  idx;
  logic [3:0]  code;
  logic        dp_sel;
  logic [3:1]  zero_dig;
  logic        lz_blank;
  logic [7:0]  seg;
  logic [7:0]  display_d;
  logic [3:0]  ctl_d;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S3;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        S0:      state_next = S1;
        S1:      state_next = S2;
        S2:      state_next = S3;
        default: state_next = S0;
      endcase
    end
  end

  // Entering S0 loads the snapshot; that same edge already displays the new
  // values, so the output path sees the incoming inputs rather than the shadow.
  assign capture    = tick && (state == S3);
  assign cap_digits = capture ? digits : sh_digits;
  assign cap_dp     = capture ? dp_in  : sh_dp;
  assign cap_blank  = capture ? blank  : sh_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= 1'b1;
    end else if (capture) begin
      sh_digits <= digits;
      sh_dp     <= dp_in;
      sh_blank  <= blank;
    end
  end

  assign idx = state_next;

  always_comb begin
    code   = cap_digits[3:0];
    dp_sel = cap_dp[0];
    case (idx)
      2'd1: begin code = cap_digits[7:4];   dp_sel = cap_dp[1]; end
      2'd2: begin code = cap_digits[11:8];  dp_sel = cap_dp[2]; end
      2'd3: begin code = cap_digits[15:12]; dp_sel = cap_dp[3]; end
      default: ;
    endcase
  end

  always_comb begin
    for (int k = 1; k < 4; k++) begin
      zero_dig[k] = (cap_digits[4*k +: 4] == 4'h0) && !cap_dp[k];
    end
  end

  // A digit is a leading zero only if it and every digit to its left are bare zeros.
  always_comb begin
    case (idx)
      2'd3:    lz_blank = zero_dig[3];
      2'd2:    lz_blank = &zero_dig[3:2];
      2'd1:    lz_blank = &zero_dig[3:1];
      default: lz_blank = 1'b0;
    endcase
    lz_blank = lz_blank && lzb_en;
  end

  ssd_decode u_decode (
    .code (code),
    .dp   (dp_sel),
    .seg  (seg)
  );

  always_comb begin
    display_d = (cap_blank || lz_blank) ? SEG_OFF : seg;
    ctl_d     = cap_blank ? DIG_OFF : ~(4'b0001 << idx);
  end

  // Output stage: display and enables move only on tick edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display     <= SEG_OFF;
      ssd_ctl     <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= capture;
      if (tick) begin
        display <= display_d;
        ssd_ctl <= ctl_d;
      end
    end
  end

endmodule
